// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults, types and helpers for the scoreboarded register file
package reg_file_pkg;

  localparam int XLEN_D  = 32;
  localparam int NREGS_D = 32;

  typedef logic [NREGS_D-1:0] busy_vec_t;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-writeback busy bits with set/clear/flush priority
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS = NREGS_D,
  parameter int NWR   = 1,
  localparam int AW   = idx_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_reg,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_reg,
  input  logic              flush,
  output logic [NREGS-1:0]  busy,
  output logic              busy_any
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             busy_any_q;

  // Order matters: writeback clears first, then a younger issue re-claims, flush overrides all.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) busy_d[wr_reg[w*AW +: AW]] = 1'b0;
    end
    if (issue_valid && issue_reg != '0) busy_d[issue_reg] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_any_q <= |busy_d;
    end
  end

  assign busy     = busy_q;
  assign busy_any = busy_any_q;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-port register file with write-first bypass and busy scoreboard
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int NREGS = NREGS_D,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = idx_w(NREGS)
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [NRD*AW-1:0]   read_reg,
  output logic [NRD*XLEN-1:0] read_data,
  output logic [NRD-1:0]      read_busy,
  input  logic [NWR-1:0]      RegWrite,
  input  logic [NWR*AW-1:0]   write_reg,
  input  logic [NWR*XLEN-1:0] write_data,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_reg,
  input  logic                flush,
  output logic                busy_any
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;

  // Later ports are applied last so the highest write port wins a same-index conflict.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (RegWrite[w] && write_reg[w*AW +: AW] != '0)
          regs_q[write_reg[w*AW +: AW]] <= write_data[w*XLEN +: XLEN];
      end
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk         (CLK),
    .rst_n       (RSTn),
    .wr_en       (RegWrite),
    .wr_reg      (write_reg),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .flush       (flush),
    .busy        (busy),
    .busy_any    (busy_any)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ridx;
    logic [XLEN-1:0] rdat;
    logic            hit;

    assign ridx = read_reg[p*AW +: AW];

    always_comb begin
      rdat = regs_q[ridx];
      hit  = 1'b0;
      for (int w = 0; w < NWR; w++) begin
        if (RegWrite[w] && write_reg[w*AW +: AW] == ridx) begin
          rdat = write_data[w*XLEN +: XLEN];
          hit  = 1'b1;
        end
      end
      if (ridx == '0) begin
        rdat = '0;
        hit  = 1'b0;
      end
    end

    // Gating with RSTn keeps a live bypass from leaking write data while reset is held.
    assign read_data[p*XLEN +: XLEN] = RSTn ? rdat : '0;
    assign read_busy[p]              = RSTn & busy[ridx] & ~hit;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-write, two-read CPU register file.
- Provides NRD combinational read ports and NWR synchronous write ports over NREGS registers of XLEN bits.
- Register 0 is hardwired to zero; reads see same-cycle writes through a write-first bypass.
- A per-register busy scoreboard lets the pipeline control detect RAW hazards on registers with a pending writeback.

Parameters:
- XLEN, 32, register width in bits.
- NREGS, 32, number of architectural registers; power of two, >= 2.
- NRD, 2, number of read ports, 1..4.
- NWR, 1, number of write ports, 1..2.
- AW, $clog2(NREGS), register index width; derived, not overridable.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- read_reg  in  NRD*AW  read indices; port p uses bits [p*AW +: AW].
- read_data  out  NRD*XLEN  read data per port.
- read_busy  out  NRD  1 = indexed register has a pending write.
- RegWrite  in  NWR  write enable per write port.
- write_reg  in  NWR*AW  write indices.
- write_data  in  NWR*XLEN  write data.
- issue_valid  in  1  an instruction with a destination register issues this cycle.
- issue_reg  in  AW  destination index of the issuing instruction.
- flush  in  1  synchronous clear of all busy bits; register contents are kept.
- busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset (RSTn=0):
  - Asynchronously clears all registers and all busy bits.
  - Outputs while reset is asserted: read_data=0, read_busy=0, busy_any=0.
  - Reset applies immediately mid-operation; any write or issue in that cycle is lost.
- Writes:
  - On a rising edge, each port w with RegWrite[w]=1 and write_reg[w]!=0 loads write_data[w].
  - A write to index 0 is ignored.
- Write conflict: if both ports target the same non-zero index in one cycle, port NWR-1 (highest index) wins.
- Reads:
  - Combinational, zero latency.
  - Index 0 always returns 0 with read_busy=0.
  - Bypass: if a write port is writing the read index this cycle, read_data returns that write_data (highest write port wins). Otherwise it returns the stored value.
- Scoreboard, per register busy bit, evaluated at each rising edge:
  - issue_valid=1 and issue_reg!=0 sets busy[issue_reg].
  - A write (RegWrite=1) to index r clears busy[r].
  - Set and clear on the same register in the same cycle: set wins, because the younger instruction owns the register.
  - flush=1 clears all busy bits and takes priority over issue. Writes during flush still update data.
  - Issuing to index 0 has no effect.
- read_busy[p]:
  - Equals busy[read_reg[p]] of the current state, masked to 0 when a same-cycle write to that index is bypassed, since the data is already valid.
  - Not masked for an issue in the same cycle; the busy bit becomes visible the next cycle.
- busy_any: registered OR of the busy vector, updated every edge; 0 after reset.
- No other state machine; latency is 0 cycles for read and bypass, 1 cycle for write and scoreboard updates.

Decomposition:
- Package reg_file_pkg:
  - default localparams XLEN_D=32, NREGS_D=32;
  - typedef of the busy vector;
  - function idx_w(n) returning $clog2(n).
- Sub-module reg_scoreboard: holds the busy vector, the set/clear/flush priority and busy_any. reg_file_sb instantiates it next to the data array and the bypass muxes.

Test Plan:
- Reset, then write 1←FFFFFFFF and 2←AAAAAAAA on port 0. Read port 0 idx 1 returns FFFFFFFF; read port 1 idx 2 returns AAAAAAAA; read_busy=0.
- Write x0←12345678, then read idx 0 on all ports: returns 00000000 with read_busy=0.
- Same cycle: write idx 5←DEADBEEF and read idx 5. read_data=DEADBEEF in that cycle (bypass) and read_busy=0; the stored value persists the next cycle.
- Issue idx 7: read_busy=1 and busy_any=1 from the next cycle. A write to 7 the same cycle as a new issue to 7 keeps busy=1. A later write clears it: busy_any=0.
- NWR=2, both ports write idx 3 (port0=11111111, port1=22222222): reading 3 returns 22222222. Issue to 4, 6 then assert flush: all read_busy=0 and data is unchanged.
- Assert RSTn=0 between clock edges after loading regs and busy bits: read_data, read_busy and busy_any go to 0 immediately, without waiting for an edge.
